// File: rtl/hsdaoh_pkg.sv
// Shared definitions for the hsdaoh stream arbiter: header framing constants
// and the arbiter state encoding.
package hsdaoh_pkg;

    // Sync nibble that opens every burst header, lets the reader resynchronise
    localparam logic [3:0] HDR_SYNC = 4'hA;

    // Header field widths and offsets for a 16-bit word; wider words place
    // the sync nibble at the top and zero-extend the sequence field
    localparam int HDR_SYNC_W   = 4;
    localparam int HDR_ID_W     = 4;
    localparam int HDR_SEQ_LSB  = 0;
    localparam int HDR_ID_LSB   = 8;
    localparam int HDR_SYNC_LSB = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } arbState_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: finds the first requesting stream
// strictly above the last granted one, wrapping back to stream 0.
module rr_arbiter #(
    parameter int NUM_STREAMS = 2,
    parameter int IDW         = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
    input  logic [NUM_STREAMS-1:0] req,
    input  logic [IDW-1:0]         last,
    output logic [IDW-1:0]         gnt_id,
    output logic                   any_req
);

    logic found;

    // Two passes: first the streams above last, then wrap to the lowest index
    always_comb begin
        gnt_id  = '0;
        any_req = |req;
        found   = 1'b0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (!found && req[i] && (IDW'(i) > last)) begin
                found  = 1'b1;
                gnt_id = IDW'(i);
            end
        end
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                gnt_id = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/hsdaoh_stream_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port between streaming
// sources. Each grant writes one header word followed by BURST_LEN payload
// words passed straight through from the granted source.
module hsdaoh_stream_arbiter
    import hsdaoh_pkg::*;
#(
    parameter int NUM_STREAMS = 2,
    parameter int DSIZE       = 16,
    parameter int BURST_LEN   = 256,
    parameter int SEQ_W       = 8,
    parameter int IDW         = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
    input  logic                     clk_data,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_STREAMS-1:0]   src_valid,
    input  logic [NUM_STREAMS*DSIZE-1:0] src_data,
    output logic [NUM_STREAMS-1:0]   src_ready,
    input  logic                     fifo_awfull,
    input  logic                     fifo_full,
    output logic                     fifo_winc,
    output logic [DSIZE-1:0]         fifo_wdata,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy,
    output logic                     burst_done
);

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);
    localparam logic [IDW-1:0] LAST_STREAM = IDW'(NUM_STREAMS - 1);

    arbState_e          state_q, state_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [IDW-1:0]     lastGrant_q, lastGrant_d;
    logic [CW-1:0]      wordCnt_q, wordCnt_d;
    logic               burstDone_q, burstDone_d;
    logic [SEQ_W-1:0]   seq_q [NUM_STREAMS];
    logic               seqInc;

    logic [IDW-1:0]     arbGnt;
    logic               arbAny;
    logic [DSIZE-1:0]   selData;
    logic               selValid;
    logic [SEQ_W-1:0]   selSeq;
    logic [HDR_ID_W-1:0] hdrId;
    logic [DSIZE-9:0]   hdrSeq;
    logic [DSIZE-1:0]   hdrWord;

    rr_arbiter #(
        .NUM_STREAMS (NUM_STREAMS),
        .IDW         (IDW)
    ) uArb (
        .req     (src_valid),
        .last    (lastGrant_q),
        .gnt_id  (arbGnt),
        .any_req (arbAny)
    );

    // Mux out the granted source's word, valid flag and sequence counter
    always_comb begin
        selData  = '0;
        selValid = 1'b0;
        selSeq   = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (grant_q == IDW'(i)) begin
                selData  = src_data[i*DSIZE +: DSIZE];
                selValid = src_valid[i];
                selSeq   = seq_q[i];
            end
        end
    end

    // Assemble the header: sync nibble, stream id, pre-increment sequence
    always_comb begin
        hdrId              = '0;
        hdrId[IDW-1:0]     = grant_q;
        hdrSeq             = '0;
        hdrSeq[SEQ_W-1:0]  = selSeq;
        hdrWord            = {HDR_SYNC, hdrId, hdrSeq};
    end

    // Next-state and output decode; all FIFO/source handshakes are combinational
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        wordCnt_d   = wordCnt_q;
        burstDone_d = 1'b0;
        seqInc      = 1'b0;
        fifo_winc   = 1'b0;
        fifo_wdata  = '0;
        src_ready   = '0;
        unique case (state_q)
            IDLE: begin
                if (enable && !fifo_awfull && arbAny) begin
                    grant_d = arbGnt;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                fifo_winc  = !fifo_full;
                fifo_wdata = hdrWord;
                if (!fifo_full) begin
                    seqInc    = 1'b1;
                    wordCnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                for (int i = 0; i < NUM_STREAMS; i++) begin
                    if (grant_q == IDW'(i)) begin
                        src_ready[i] = !fifo_full;
                    end
                end
                fifo_winc  = selValid && !fifo_full;
                fifo_wdata = selData;
                if (selValid && !fifo_full) begin
                    wordCnt_d = wordCnt_q + 1'b1;
                    if (wordCnt_q == LAST_CNT) begin
                        lastGrant_d = grant_q;
                        burstDone_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant bookkeeping and per-stream sequence counters
    always_ff @(posedge clk_data) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            lastGrant_q <= LAST_STREAM;
            wordCnt_q   <= '0;
            burstDone_q <= 1'b0;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                seq_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            wordCnt_q   <= wordCnt_d;
            burstDone_q <= burstDone_d;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                if (seqInc && (grant_q == IDW'(i))) begin
                    seq_q[i] <= seq_q[i] + 1'b1;
                end
            end
        end
    end

    assign grant_id   = grant_q;
    assign busy       = (state_q != IDLE);
    assign burst_done = burstDone_q;

endmodule

// File: tb/tb_hsdaoh_stream_arbiter.sv
// Directed bench for the hsdaoh stream arbiter: a cycle table covering
// single/dual stream bursts, awfull hold-off, full stalls and source stalls,
// followed by sequence wrap, mid-burst reset and enable-drop sequences.
module tb_hsdaoh_stream_arbiter;

    localparam int NS = 2;
    localparam int DW = 16;
    localparam int BL = 4;
    localparam int SW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  src_valid;
    logic [15:0] d0, d1;
    logic [31:0] src_data;
    logic [1:0]  src_ready;
    logic        fifo_awfull;
    logic        fifo_full;
    logic        fifo_winc;
    logic [15:0] fifo_wdata;
    logic [0:0]  grant_id;
    logic        busy;
    logic        burst_done;

    int errors = 0;
    int checks = 0;

    assign src_data = {d1, d0};

    always #5 clk = ~clk;

    hsdaoh_stream_arbiter #(
        .NUM_STREAMS (NS),
        .DSIZE       (DW),
        .BURST_LEN   (BL),
        .SEQ_W       (SW)
    ) dut (
        .clk_data    (clk),
        .rst         (rst),
        .enable      (enable),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .fifo_awfull (fifo_awfull),
        .fifo_full   (fifo_full),
        .fifo_winc   (fifo_winc),
        .fifo_wdata  (fifo_wdata),
        .grant_id    (grant_id),
        .busy        (busy),
        .burst_done  (burst_done)
    );

    typedef struct {
        logic        en;
        logic        awf;
        logic        full;
        logic [1:0]  vld;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        eWinc;
        logic [15:0] eWdata;
        logic [1:0]  eRdy;
        logic        eBusy;
        logic        eDone;
        logic        eGid;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input logic en, input logic awf, input logic full,
                                   input logic [1:0] vld, input logic [15:0] a0,
                                   input logic [15:0] a1, input logic eWinc,
                                   input logic [15:0] eWdata, input logic [1:0] eRdy,
                                   input logic eBusy, input logic eDone, input logic eGid);
        vec_t v;
        v.en = en; v.awf = awf; v.full = full; v.vld = vld; v.d0 = a0; v.d1 = a1;
        v.eWinc = eWinc; v.eWdata = eWdata; v.eRdy = eRdy;
        v.eBusy = eBusy; v.eDone = eDone; v.eGid = eGid;
        vecs.push_back(v);
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        enable      = v.en;
        fifo_awfull = v.awf;
        fifo_full   = v.full;
        src_valid   = v.vld;
        d0          = v.d0;
        d1          = v.d1;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkVal({tag, "_winc"},  32'(fifo_winc),  32'(v.eWinc));
        checkVal({tag, "_wdata"}, 32'(fifo_wdata), 32'(v.eWdata));
        checkVal({tag, "_ready"}, 32'(src_ready),  32'(v.eRdy));
        checkVal({tag, "_busy"},  32'(busy),       32'(v.eBusy));
        checkVal({tag, "_done"},  32'(burst_done), 32'(v.eDone));
        checkVal({tag, "_gid"},   32'(grant_id),   32'(v.eGid));
    endtask

    task automatic checkIdleZero(input string tag);
        checkVal({tag, "_winc"},  32'(fifo_winc),  0);
        checkVal({tag, "_wdata"}, 32'(fifo_wdata), 0);
        checkVal({tag, "_ready"}, 32'(src_ready),  0);
        checkVal({tag, "_busy"},  32'(busy),       0);
        checkVal({tag, "_done"},  32'(burst_done), 0);
        checkVal({tag, "_gid"},   32'(grant_id),   0);
    endtask

    // Watchdog so a stuck design still ends the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hdrCnt;
        int wr;
        int dn;

        // en, awf, full, vld, d0, d1 | winc, wdata, ready, busy, done, gid
        addVec(1,0,0,2'b01,16'h0000,16'h0000, 0,16'h0000,2'b00,0,0,0);
        addVec(1,0,0,2'b01,16'h0D00,16'h0000, 1,16'hA000,2'b00,1,0,0);
        addVec(1,0,0,2'b01,16'h0D00,16'h0000, 1,16'h0D00,2'b01,1,0,0);
        addVec(1,0,0,2'b01,16'h0D01,16'h0000, 1,16'h0D01,2'b01,1,0,0);
        addVec(1,0,0,2'b01,16'h0D02,16'h0000, 1,16'h0D02,2'b01,1,0,0);
        addVec(1,0,0,2'b01,16'h0D03,16'h0000, 1,16'h0D03,2'b01,1,0,0);
        addVec(1,0,0,2'b01,16'h0000,16'h0000, 0,16'h0000,2'b00,0,1,0);
        addVec(1,0,0,2'b01,16'h0D04,16'h0000, 1,16'hA001,2'b00,1,0,0);
        addVec(1,0,0,2'b01,16'h0D04,16'h0000, 1,16'h0D04,2'b01,1,0,0);
        addVec(1,0,0,2'b01,16'h0D05,16'h0000, 1,16'h0D05,2'b01,1,0,0);
        addVec(1,0,0,2'b01,16'h0D06,16'h0000, 1,16'h0D06,2'b01,1,0,0);
        addVec(1,0,0,2'b01,16'h0D07,16'h0000, 1,16'h0D07,2'b01,1,0,0);
        addVec(1,0,0,2'b11,16'hBEEF,16'h1D00, 0,16'h0000,2'b00,0,1,0);
        addVec(1,0,0,2'b11,16'hBEEF,16'h1D00, 1,16'hA100,2'b00,1,0,1);
        addVec(1,0,0,2'b11,16'hBEEF,16'h1D00, 1,16'h1D00,2'b10,1,0,1);
        addVec(1,0,0,2'b11,16'hBEEF,16'h1D01, 1,16'h1D01,2'b10,1,0,1);
        addVec(1,0,0,2'b11,16'hBEEF,16'h1D02, 1,16'h1D02,2'b10,1,0,1);
        addVec(1,0,0,2'b11,16'hBEEF,16'h1D03, 1,16'h1D03,2'b10,1,0,1);
        addVec(1,0,0,2'b11,16'h0D08,16'hCAFE, 0,16'h0000,2'b00,0,1,1);
        addVec(1,0,0,2'b11,16'h0D08,16'hCAFE, 1,16'hA002,2'b00,1,0,0);
        addVec(1,0,0,2'b11,16'h0D08,16'hCAFE, 1,16'h0D08,2'b01,1,0,0);
        addVec(1,0,0,2'b10,16'h0D09,16'hCAFE, 0,16'h0D09,2'b01,1,0,0);
        addVec(1,0,0,2'b11,16'h0D09,16'hCAFE, 1,16'h0D09,2'b01,1,0,0);
        addVec(1,0,0,2'b11,16'h0D0A,16'hCAFE, 1,16'h0D0A,2'b01,1,0,0);
        addVec(1,0,0,2'b11,16'h0D0B,16'hCAFE, 1,16'h0D0B,2'b01,1,0,0);
        addVec(1,1,0,2'b11,16'h0000,16'h0000, 0,16'h0000,2'b00,0,1,0);
        addVec(1,1,0,2'b11,16'h0000,16'h0000, 0,16'h0000,2'b00,0,0,0);
        addVec(1,0,0,2'b11,16'h0000,16'h0000, 0,16'h0000,2'b00,0,0,0);
        addVec(1,0,0,2'b11,16'hBEEF,16'h1D04, 1,16'hA101,2'b00,1,0,1);
        addVec(1,1,0,2'b11,16'hBEEF,16'h1D04, 1,16'h1D04,2'b10,1,0,1);
        addVec(1,0,1,2'b11,16'hBEEF,16'h1D05, 0,16'h1D05,2'b00,1,0,1);
        addVec(1,0,1,2'b11,16'hBEEF,16'h1D05, 0,16'h1D05,2'b00,1,0,1);
        addVec(1,0,1,2'b11,16'hBEEF,16'h1D05, 0,16'h1D05,2'b00,1,0,1);
        addVec(1,0,0,2'b11,16'hBEEF,16'h1D05, 1,16'h1D05,2'b10,1,0,1);
        addVec(1,0,0,2'b11,16'hBEEF,16'h1D06, 1,16'h1D06,2'b10,1,0,1);
        addVec(1,0,0,2'b11,16'hBEEF,16'h1D07, 1,16'h1D07,2'b10,1,0,1);
        addVec(0,0,0,2'b11,16'h0000,16'h0000, 0,16'h0000,2'b00,0,1,1);
        addVec(0,0,0,2'b11,16'h0000,16'h0000, 0,16'h0000,2'b00,0,0,1);

        // Reset with requests pending: everything must sit at zero
        rst = 1'b1; enable = 1'b1; src_valid = 2'b11;
        fifo_awfull = 1'b0; fifo_full = 1'b0; d0 = 16'h1111; d1 = 16'h2222;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkIdleZero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] cycle table: %0d vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("v%0d", i), vecs[i]);
            @(posedge clk);
            #1;
        end

        // Sequence wrap: 257 back-to-back bursts on stream 0
        $display("[TB] sequence wrap");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; enable = 1'b1; src_valid = 2'b01;
        fifo_awfull = 1'b0; fifo_full = 1'b0; d0 = 16'h0055; d1 = 16'h0066;
        hdrCnt = 0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            @(negedge clk);
            if (fifo_winc && (fifo_wdata[15:12] == 4'hA)) begin
                checkVal($sformatf("wrap_hdr%0d", hdrCnt), 32'(fifo_wdata),
                         {16'h0000, 4'hA, 4'h0, 8'(hdrCnt)});
                if (hdrCnt == 256) begin
                    checkVal("wrap_cycle", cyc, 1 + 6 * 256);
                end
                hdrCnt++;
                if (hdrCnt == 257) begin
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        checkVal("wrap_count", hdrCnt, 257);

        // Reset after two payload words of the current burst
        $display("[TB] reset mid-burst");
        @(posedge clk);
        #1;
        @(negedge clk);
        checkVal("rst_pre_w0", 32'(fifo_wdata), 32'h0055);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1; src_valid = 2'b11;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkIdleZero("rst_after");
        @(posedge clk);
        #1;
        @(negedge clk);
        checkVal("rst_hdr_winc", 32'(fifo_winc), 1);
        checkVal("rst_hdr_data", 32'(fifo_wdata), 32'hA000);
        checkVal("rst_hdr_gid", 32'(grant_id), 0);

        // Drop enable once the burst is under way: it must complete, then idle
        $display("[TB] enable drop mid-burst");
        @(posedge clk);
        #1;
        enable = 1'b0; src_valid = 2'b01;
        wr = 0; dn = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (fifo_winc) wr++;
            if (burst_done) dn++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkVal("endrop_writes", wr, BL);
        checkVal("endrop_done", dn, 1);
        checkVal("endrop_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
